data_sram_responder: RTL and testbench

Memory-side responder for the data SRAM-like interface driven by the CPU pipeline's EX stage (request) and MEM stage (response). It accepts load and store requests with an address handshake, performs byte-lane writes into an internal word-organised array, and returns read data in order after a fixed latency. Outstanding requests are held in a small in-order response queue. It serves as the bench and FPGA stand-in for the data memory.

---
 rtl/data_sram_responder.sv | 120 ++++++++++++
 tb/tb_data_sram_responder.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Data memory stand-in: word-organised array with byte-lane stores and an in-order,
// fixed-latency response queue.
module data_sram_responder #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned QDEPTH  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        data_err
);

  localparam int unsigned Words = 2 ** ADDR_W;
  localparam int unsigned PtrW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW  = $clog2(QDEPTH + 1);
  localparam int unsigned CdW   = 3;
  localparam logic [CdW-1:0] CdInit = CdW'(LATENCY - 1);

  logic [31:0] mem_q [Words];

  logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [QDEPTH-1:0] valid_q, valid_d, err_q, err_d;
  logic [31:0]       data_q [QDEPTH];
  logic [31:0]       data_d [QDEPTH];
  logic [CdW-1:0]    cd_q [QDEPTH];
  logic [CdW-1:0]    cd_d [QDEPTH];

  logic [ADDR_W-1:0] idx;
  logic              misalign, full, accept, pop;
  logic              unused_addr;

  assign idx         = addr[ADDR_W+1:2];
  assign unused_addr = ^addr[31:ADDR_W+2];
  assign misalign    = ((size == 2'd1) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));

  // A pop does not free its slot in the same cycle, so full depends on count alone.
  assign full    = (count_q == CntW'(QDEPTH));
  assign addr_ok = req & ~full;
  assign accept  = req & addr_ok & resetn;

  assign data_ok  = valid_q[head_q] && (cd_q[head_q] == '0);
  assign pop      = data_ok;
  assign rdata    = data_ok ? data_q[head_q] : 32'h0;
  assign data_err = data_ok & err_q[head_q];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Array is not reset; accepted stores survive a mid-operation reset.
  always_ff @(posedge clk) begin
    if (accept && wr && !misalign) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wstrb[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    err_d   = err_q;
    data_d  = data_q;
    cd_d    = cd_q;
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      if (valid_q[i] && (cd_q[i] != '0)) cd_d[i] = cd_q[i] - 1'b1;
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = ptr_inc(head_q);
    end
    if (accept) begin
      valid_d[tail_q] = 1'b1;
      err_d[tail_q]   = misalign;
      cd_d[tail_q]    = CdInit;
      data_d[tail_q]  = wr ? 32'h0 : mem_q[idx];
      tail_d          = ptr_inc(tail_q);
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      err_q   <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        data_q[i] <= '0;
        cd_q[i]   <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      data_q  <= data_d;
      cd_q    <= cd_d;
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: two instances (QDEPTH/LATENCY 2/2 and 1/3) checked
// every cycle against a queue-based reference model, plus directed scenarios.
module tb_data_sram_responder;

  localparam int unsigned AW    = 8;
  localparam int unsigned Words = 2 ** AW;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
    logic [31:0] mask;
    logic        err;
  } resp_t;

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
    logic        err;
  } log_t;

  logic        clk, resetn;
  logic [1:0]  req_v, wr_v, aok, dok, derr;
  logic [1:0]  size_v [2];
  logic [31:0] addr_v [2];
  logic [3:0]  wstrb_v [2];
  logic [31:0] wdata_v [2];
  logic [31:0] rd [2];

  int unsigned qd  [2] = '{2, 1};
  int unsigned lat [2] = '{2, 3};

  resp_t       exp_q [2][$];
  log_t        log_q [2][$];
  logic [31:0] mmem [2][Words];
  logic [3:0]  kn [2][Words];
  logic [1:0]  acc;
  int unsigned cyc;
  int          checks, errors;

  data_sram_responder #(.ADDR_W(AW), .LATENCY(2), .QDEPTH(2)) dut0 (
    .clk(clk), .resetn(resetn), .req(req_v[0]), .wr(wr_v[0]), .size(size_v[0]),
    .addr(addr_v[0]), .wstrb(wstrb_v[0]), .wdata(wdata_v[0]), .addr_ok(aok[0]),
    .data_ok(dok[0]), .rdata(rd[0]), .data_err(derr[0])
  );

  data_sram_responder #(.ADDR_W(AW), .LATENCY(3), .QDEPTH(1)) dut1 (
    .clk(clk), .resetn(resetn), .req(req_v[1]), .wr(wr_v[1]), .size(size_v[1]),
    .addr(addr_v[1]), .wstrb(wstrb_v[1]), .wdata(wdata_v[1]), .addr_ok(aok[1]),
    .data_ok(dok[1]), .rdata(rd[1]), .data_err(derr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] bmask(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  task automatic set_idle();
    for (int d = 0; d < 2; d++) begin
      req_v[d] = 1'b0; wr_v[d] = 1'b0; size_v[d] = 2'd2;
      addr_v[d] = 32'h0; wstrb_v[d] = 4'h0; wdata_v[d] = 32'h0;
    end
  endtask

  // Reference: memory as bytes with known-flags; responses due LATENCY cycles after acceptance.
  task automatic model_accept(input int d);
    int unsigned w;
    logic        mis;
    resp_t       r;
    w   = (addr_v[d] / 4) % Words;
    mis = (size_v[d] == 2'd1 && addr_v[d] % 2 != 0) || (size_v[d] >= 2'd2 && addr_v[d] % 4 != 0);
    r.due = cyc + lat[d] - 1;
    r.err = mis;
    if (wr_v[d]) begin
      if (!mis) begin
        for (int i = 0; i < 4; i++) begin
          if (wstrb_v[d][i]) begin
            mmem[d][w][8*i +: 8] = wdata_v[d][8*i +: 8];
            kn[d][w][i] = 1'b1;
          end
        end
      end
      r.data = 32'h0;
      r.mask = 32'hFFFF_FFFF;
    end else begin
      r.data = mmem[d][w];
      r.mask = bmask(kn[d][w]);
    end
    exp_q[d].push_back(r);
  endtask

  // Called at a falling edge; checks the low phase, clocks once, returns at the next falling edge.
  task automatic step();
    logic [1:0] ok_now, aok_now;
    resp_t      r;
    log_t       l;
    #1;
    for (int d = 0; d < 2; d++) begin
      ok_now[d]  = (exp_q[d].size() > 0) && (exp_q[d][0].due == cyc);
      aok_now[d] = req_v[d] && (exp_q[d].size() < qd[d]);
      checks++;
      if (aok[d] !== aok_now[d]) begin
        errors++;
        $display("FAIL addr_ok dut%0d cyc %0d: got %b want %b", d, cyc, aok[d], aok_now[d]);
      end
      checks++;
      if (dok[d] !== ok_now[d]) begin
        errors++;
        $display("FAIL data_ok dut%0d cyc %0d: got %b want %b", d, cyc, dok[d], ok_now[d]);
      end
      checks++;
      if (ok_now[d]) begin
        r = exp_q[d][0];
        if ((((rd[d] ^ r.data) & r.mask) !== 32'h0) || (derr[d] !== r.err)) begin
          errors++;
          $display("FAIL resp dut%0d cyc %0d: got %h/%b want %h/%b (mask %h)",
                   d, cyc, rd[d], derr[d], r.data, r.err, r.mask);
        end
      end else if ((rd[d] !== 32'h0) || (derr[d] !== 1'b0)) begin
        errors++;
        $display("FAIL idle_out dut%0d cyc %0d: got %h/%b want 0/0", d, cyc, rd[d], derr[d]);
      end
      if (dok[d] === 1'b1) begin
        l.cyc = cyc; l.data = rd[d]; l.err = derr[d];
        log_q[d].push_back(l);
      end
    end
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (ok_now[d]) void'(exp_q[d].pop_front());
      acc[d] = aok_now[d];
      if (aok_now[d]) model_accept(d);
    end
    @(negedge clk);
  endtask

  // Hold one request on instance d until the model says it is accepted.
  task automatic issue(input int d, input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [3:0] st, input logic [31:0] wd, output int unsigned acc_cyc);
    int n;
    set_idle();
    req_v[d] = 1'b1; wr_v[d] = w; size_v[d] = sz; addr_v[d] = a;
    wstrb_v[d] = st; wdata_v[d] = wd;
    acc[d] = 1'b0;
    n = 0;
    while (!acc[d] && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (!acc[d]) begin
      errors++;
      $display("FAIL issue_timeout dut%0d addr %h: got not accepted want accepted", d, a);
    end
    acc_cyc = cyc;
    set_idle();
  endtask

  task automatic drain();
    int n;
    set_idle();
    n = 0;
    while ((exp_q[0].size() > 0 || exp_q[1].size() > 0) && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (exp_q[0].size() > 0 || exp_q[1].size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d/%0d pending want 0/0", exp_q[0].size(), exp_q[1].size());
    end
  endtask

  task automatic do_reset();
    set_idle();
    resetn = 1'b0;
    // Requests during the reset cycle must be ignored.
    for (int d = 0; d < 2; d++) begin
      req_v[d] = 1'b1; wr_v[d] = 1'b1; addr_v[d] = 32'h100;
      wstrb_v[d] = 4'hF; wdata_v[d] = 32'h1111_1111;
    end
    @(posedge clk);
    cyc++;
    exp_q[0].delete();
    exp_q[1].delete();
    @(negedge clk);
    resetn = 1'b1;
    set_idle();
  endtask

  task automatic check_last(input int d, input string name, input logic [31:0] want_d,
                            input logic want_e);
    checks++;
    if (log_q[d].size() == 0) begin
      errors++;
      $display("FAIL %s dut%0d: got no response want %h", name, d, want_d);
    end else if (log_q[d][$].data !== want_d || log_q[d][$].err !== want_e) begin
      errors++;
      $display("FAIL %s dut%0d: got %h/%b want %h/%b", name, d, log_q[d][$].data,
               log_q[d][$].err, want_d, want_e);
    end
  endtask

  task automatic test_reset();
    set_idle();
    step();
    req_v[0] = 1'b1; wr_v[0] = 1'b1; addr_v[0] = 32'h200; wstrb_v[0] = 4'hF; wdata_v[0] = 32'h5;
    req_v[1] = 1'b1; wr_v[1] = 1'b1; addr_v[1] = 32'h200; wstrb_v[1] = 4'hF; wdata_v[1] = 32'h6;
    step();
    drain();
  endtask

  task automatic test_word(input int d);
    int unsigned c;
    log_q[d].delete();
    issue(d, 1'b1, 2'd2, 32'h100, 4'hF, 32'hDEAD_BEEF, c);
    issue(d, 1'b0, 2'd2, 32'h100, 4'h0, 32'h0, c);
    drain();
    check_last(d, "word_load", 32'hDEAD_BEEF, 1'b0);
    checks++;
    if (log_q[d].size() == 0 || log_q[d][$].cyc != c + lat[d] - 1) begin
      errors++;
      $display("FAIL word_latency dut%0d: got %0d responses want data_ok at cyc %0d",
               d, log_q[d].size(), c + lat[d] - 1);
    end
  endtask

  task automatic test_byte_lane(input int d);
    int unsigned c;
    log_q[d].delete();
    issue(d, 1'b1, 2'd0, 32'h102, 4'b0100, 32'h00AA_0000, c);
    issue(d, 1'b0, 2'd2, 32'h100, 4'h0, 32'h0, c);
    drain();
    check_last(d, "byte_lane", 32'hDEAA_BEEF, 1'b0);
  endtask

  task automatic test_back_to_back();
    int unsigned c;
    for (int i = 0; i < 4; i++) issue(0, 1'b1, 2'd2, 32'(4 * i), 4'hF, 32'(i + 1), c);
    drain();
    log_q[0].delete();
    for (int i = 0; i < 4; i++) issue(0, 1'b0, 2'd2, 32'(4 * i), 4'h0, 32'h0, c);
    drain();
    checks++;
    if (log_q[0].size() != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 4", log_q[0].size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (log_q[0][i].data !== 32'(i + 1)) begin
          errors++;
          $display("FAIL b2b_order[%0d]: got %h want %h", i, log_q[0][i].data, i + 1);
        end
      end
    end
  endtask

  task automatic test_full();
    int unsigned c1, c2;
    log_q[1].delete();
    issue(1, 1'b0, 2'd2, 32'h100, 4'h0, 32'h0, c1);
    issue(1, 1'b0, 2'd2, 32'h0, 4'h0, 32'h0, c2);
    drain();
    // First retires at c1+2, slot frees at the next edge, second accepted one edge later.
    checks++;
    if (c2 != c1 + 4) begin
      errors++;
      $display("FAIL full_accept_gap: got %0d want 4", c2 - c1);
    end
    checks++;
    if (log_q[1].size() != 2 || log_q[1][0].cyc != c1 + 2 || log_q[1][1].cyc != c2 + 2) begin
      errors++;
      $display("FAIL full_resp_timing: got %0d responses want 2 at cyc %0d and %0d",
               log_q[1].size(), c1 + 2, c2 + 2);
    end
  endtask

  task automatic test_misaligned(input int d);
    int unsigned c;
    log_q[d].delete();
    issue(d, 1'b1, 2'd2, 32'h101, 4'hF, 32'h1234_5678, c);
    drain();
    check_last(d, "misaligned_store_err", 32'h0, 1'b1);
    issue(d, 1'b0, 2'd2, 32'h100, 4'h0, 32'h0, c);
    drain();
    check_last(d, "misaligned_no_write", 32'hDEAA_BEEF, 1'b0);
  endtask

  task automatic test_reset_mid();
    int unsigned c;
    issue(0, 1'b0, 2'd2, 32'h100, 4'h0, 32'h0, c);
    issue(0, 1'b0, 2'd2, 32'h0, 4'h0, 32'h0, c);
    do_reset();
    log_q[0].delete();
    repeat (5) step();
    checks++;
    if (log_q[0].size() != 0) begin
      errors++;
      $display("FAIL reset_drop: got %0d responses want 0", log_q[0].size());
    end
    issue(0, 1'b0, 2'd2, 32'h100, 4'h0, 32'h0, c);
    drain();
    check_last(0, "reset_keeps_mem", 32'hDEAA_BEEF, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++) begin
        req_v[d]   = ($urandom % 4) != 0;
        wr_v[d]    = $urandom % 2;
        size_v[d]  = 2'($urandom % 4);
        addr_v[d]  = ($urandom & 32'h0000_03FF) | ((($urandom % 8) == 0) ? ($urandom & 32'hFFFF_FC00) : 32'h0);
        wstrb_v[d] = 4'($urandom);
        wdata_v[d] = $urandom;
      end
      step();
    end
    drain();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    acc    = '0;
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < Words; w++) begin
        kn[d][w]   = 4'h0;
        mmem[d][w] = 32'h0;
      end
    end
    set_idle();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    test_reset();
    test_word(0);
    test_word(1);
    test_byte_lane(0);
    test_byte_lane(1);
    test_back_to_back();
    test_full();
    test_misaligned(0);
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
